// File: rtl/adpcm_d.sv
// IMA/DVI ADPCM decoder: one 4-bit code in, one 16-bit PCM sample out per cycle.
// Predictor and step index restart from zero at every packet start.
module adpcm_d #(
   parameter int WIDTH  = 16,
   parameter int DWIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             sop,
   input  logic             eop,
   input  logic [3:0]       coded,
   output logic [WIDTH-1:0] decoded
);

   localparam logic signed [DWIDTH+1:0] IDX_MAX = (DWIDTH+2)'(88);
   localparam logic signed [DWIDTH+1:0] IDX_MIN = '0;

   logic signed [WIDTH-1:0] pred_reg;
   logic [DWIDTH-1:0]       idx_reg;
   logic                    active_reg;
   logic [WIDTH-1:0]        decoded_reg;

   logic                    valid;
   logic signed [WIDTH-1:0] base_pred;
   logic [DWIDTH-1:0]       base_idx;
   logic [15:0]             step;
   logic [16:0]             term [3];
   logic [16:0]             diff;
   logic signed [17:0]      pred_ext;
   logic signed [17:0]      diff_ext;
   logic signed [17:0]      sum;
   logic [WIDTH-1:0]        pred_next;
   logic signed [4:0]       adj;
   logic signed [DWIDTH+1:0] idx_sum;
   logic [DWIDTH-1:0]       idx_next;
   logic                    active_next;

   function automatic logic [15:0] step_rom(input int i);
      logic [15:0] s;
      s = 16'd32767;
      case (i)
         0: s = 16'd7;      1: s = 16'd8;      2: s = 16'd9;      3: s = 16'd10;
         4: s = 16'd11;     5: s = 16'd12;     6: s = 16'd13;     7: s = 16'd14;
         8: s = 16'd16;     9: s = 16'd17;     10: s = 16'd19;    11: s = 16'd21;
         12: s = 16'd23;    13: s = 16'd25;    14: s = 16'd28;    15: s = 16'd31;
         16: s = 16'd34;    17: s = 16'd37;    18: s = 16'd41;    19: s = 16'd45;
         20: s = 16'd50;    21: s = 16'd55;    22: s = 16'd60;    23: s = 16'd66;
         24: s = 16'd73;    25: s = 16'd80;    26: s = 16'd88;    27: s = 16'd97;
         28: s = 16'd107;   29: s = 16'd118;   30: s = 16'd130;   31: s = 16'd143;
         32: s = 16'd157;   33: s = 16'd173;   34: s = 16'd190;   35: s = 16'd209;
         36: s = 16'd230;   37: s = 16'd253;   38: s = 16'd279;   39: s = 16'd307;
         40: s = 16'd337;   41: s = 16'd371;   42: s = 16'd408;   43: s = 16'd449;
         44: s = 16'd494;   45: s = 16'd544;   46: s = 16'd598;   47: s = 16'd658;
         48: s = 16'd724;   49: s = 16'd796;   50: s = 16'd876;   51: s = 16'd963;
         52: s = 16'd1060;  53: s = 16'd1166;  54: s = 16'd1282;  55: s = 16'd1411;
         56: s = 16'd1552;  57: s = 16'd1707;  58: s = 16'd1878;  59: s = 16'd2066;
         60: s = 16'd2272;  61: s = 16'd2499;  62: s = 16'd2749;  63: s = 16'd3024;
         64: s = 16'd3327;  65: s = 16'd3660;  66: s = 16'd4026;  67: s = 16'd4428;
         68: s = 16'd4871;  69: s = 16'd5358;  70: s = 16'd5894;  71: s = 16'd6484;
         72: s = 16'd7132;  73: s = 16'd7845;  74: s = 16'd8630;  75: s = 16'd9493;
         76: s = 16'd10442; 77: s = 16'd11487; 78: s = 16'd12635; 79: s = 16'd13899;
         80: s = 16'd15289; 81: s = 16'd16818; 82: s = 16'd18500; 83: s = 16'd20350;
         84: s = 16'd22385; 85: s = 16'd24623; 86: s = 16'd27086; 87: s = 16'd29794;
         default: s = 16'd32767;
      endcase
      return s;
   endfunction

   assign valid     = sop | active_reg;
   assign base_pred = sop ? '0 : pred_reg;
   assign base_idx  = sop ? '0 : idx_reg;
   assign step      = step_rom(int'(base_idx));

   // Magnitude bit gi contributes step >> (2-gi)
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_term
         assign term[gi] = coded[gi] ? 17'({1'b0, step} >> (2 - gi)) : 17'd0;
      end
   endgenerate

   assign diff     = 17'(step >> 3) + term[0] + term[1] + term[2];
   assign pred_ext = 18'(base_pred);
   assign diff_ext = signed'({1'b0, diff});

   always_comb begin
      sum       = coded[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
      pred_next = sum[WIDTH-1:0];
      if (sum > 18'sd32767)
         pred_next = 16'h7fff;
      else if (sum < -18'sd32768)
         pred_next = 16'h8000;
   end

   always_comb begin
      adj = -5'sd1;
      case (coded[2:0])
         3'd4:    adj = 5'sd2;
         3'd5:    adj = 5'sd4;
         3'd6:    adj = 5'sd6;
         3'd7:    adj = 5'sd8;
         default: adj = -5'sd1;
      endcase
      idx_sum  = signed'({2'b00, base_idx}) + (DWIDTH+2)'(adj);
      idx_next = idx_sum[DWIDTH-1:0];
      if (idx_sum > IDX_MAX)
         idx_next = DWIDTH'(88);
      else if (idx_sum < IDX_MIN)
         idx_next = '0;
   end

   // eop wins over sop, so a one-nibble packet leaves the decoder idle
   assign active_next = eop ? 1'b0 : (sop ? 1'b1 : active_reg);

   always_ff @(posedge clk) begin
      if (!nrst) begin
         pred_reg    <= '0;
         idx_reg     <= '0;
         active_reg  <= 1'b0;
         decoded_reg <= '0;
      end else begin
         active_reg <= active_next;
         if (valid) begin
            pred_reg    <= pred_next;
            idx_reg     <= idx_next;
            decoded_reg <= pred_next;
         end
      end
   end

   assign decoded = decoded_reg;

endmodule

// File: tb/tb_adpcm_d.sv
// Directed bench for adpcm_d: hand-computed IMA decode results checked
// with immediate assertions after each clock.
module tb_adpcm_d;

   logic        clk = 1'b0;
   logic        nrst;
   logic        sop;
   logic        eop;
   logic [3:0]  coded;
   logic [15:0] decoded;

   int n_cmp = 0;
   int n_err = 0;

   adpcm_d #(.WIDTH(16), .DWIDTH(8)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .sop     (sop),
      .eop     (eop),
      .coded   (coded),
      .decoded (decoded)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic s, input logic e, input logic [3:0] c);
      sop   = s;
      eop   = e;
      coded = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [15:0] exp);
      n_cmp++;
      $display("t=%0t %s sop=%b eop=%b coded=%h decoded=%0d", $time, tag, sop, eop, coded,
               $signed(decoded));
      assert (decoded === exp) else begin
         n_err++;
         $error("FAIL %s: decoded=%0d expected=%0d", tag, $signed(decoded), exp);
      end
   endtask

   initial begin
      nrst  = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
      coded = 4'h0;

      // Reset with random controls
      drive(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
      drive(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
      check("reset", 16'sd0);
      nrst = 1'b1;
      drive(1'b0, 1'b0, 4'h7);
      drive(1'b0, 1'b0, 4'h7);
      check("idle_after_reset", 16'sd0);

      // Positive decode
      drive(1'b1, 1'b0, 4'h7);
      check("pos_first", 16'sd11);
      drive(1'b0, 1'b0, 4'h7);
      check("pos_second", 16'sd41);

      // Negative decode
      drive(1'b1, 1'b0, 4'hF);
      check("neg_first", -16'sd11);

      // Index floor: idx stays 0, so a later 0x7 still uses step 7
      drive(1'b1, 1'b0, 4'h0);
      check("floor_zero", 16'sd0);
      drive(1'b0, 1'b0, 4'h0);
      check("floor_zero2", 16'sd0);
      drive(1'b0, 1'b0, 4'h7);
      check("floor_then_pos", 16'sd11);

      // Positive saturation
      drive(1'b1, 1'b0, 4'h7);
      for (int i = 0; i < 38; i++) drive(1'b0, 1'b0, 4'h7);
      check("sat_pos_39", 16'sd32767);
      drive(1'b0, 1'b0, 4'h7);
      check("sat_pos_40", 16'sd32767);
      // idx 88: diff = 4095+32767+16383+8191 = 61436
      drive(1'b0, 1'b0, 4'hF);
      check("idx88_down", -16'sd28669);

      // Negative saturation
      drive(1'b1, 1'b0, 4'hF);
      for (int i = 0; i < 38; i++) drive(1'b0, 1'b0, 4'hF);
      check("sat_neg_39", -16'sd32768);
      drive(1'b0, 1'b0, 4'hF);
      check("sat_neg_40", -16'sd32768);
      drive(1'b0, 1'b0, 4'h7);
      check("idx88_up", 16'sd28668);

      // Four-nibble packet then idle
      drive(1'b1, 1'b0, 4'h7);
      check("pkt_n0", 16'sd11);
      drive(1'b0, 1'b0, 4'h7);
      check("pkt_n1", 16'sd41);
      drive(1'b0, 1'b0, 4'h4);
      check("pkt_n2", 16'sd79);
      drive(1'b0, 1'b1, 4'h9);
      check("pkt_eop", 16'sd64);
      drive(1'b0, 1'b0, 4'h7);
      drive(1'b0, 1'b0, 4'hC);
      drive(1'b0, 1'b0, 4'h3);
      check("idle_hold", 16'sd64);
      drive(1'b0, 1'b1, 4'h7);
      check("stray_eop", 16'sd64);

      // Restart with and without a preceding eop
      drive(1'b1, 1'b0, 4'h7);
      check("restart", 16'sd11);
      drive(1'b0, 1'b0, 4'h7);
      check("restart_n1", 16'sd41);
      drive(1'b1, 1'b0, 4'h7);
      check("sop_mid_pkt", 16'sd11);

      // One-nibble packet
      drive(1'b1, 1'b1, 4'h7);
      check("single_nibble", 16'sd11);
      drive(1'b0, 1'b0, 4'h7);
      drive(1'b0, 1'b0, 4'hF);
      check("single_hold", 16'sd11);

      // Reset mid-packet
      drive(1'b1, 1'b0, 4'h7);
      drive(1'b0, 1'b0, 4'h7);
      check("pre_reset", 16'sd41);
      nrst = 1'b0;
      drive(1'b1, 1'b0, 4'h7);
      check("mid_reset", 16'sd0);
      nrst = 1'b1;
      drive(1'b0, 1'b0, 4'h7);
      drive(1'b0, 1'b0, 4'h5);
      check("post_reset_ignored", 16'sd0);
      drive(1'b1, 1'b0, 4'h7);
      check("post_reset_sop", 16'sd11);

      drive(1'b0, 1'b0, 4'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adpcm_d.md
# adpcm_d

IMA/DVI ADPCM decoder for the MP3-player audio path. Each clock cycle inside a packet it takes one 4-bit ADPCM code and produces one 16-bit signed PCM sample. Packets are delimited by `sop`/`eop`. The predictor state (sample and step index) is re-initialised at every packet start.

## Interface
- WIDTH, 16: PCM sample width. Only 16 is supported, because the step table and the clamping are 16-bit.
- DWIDTH, 8: width of the internal step-index register. Must be ≥ 7.
- clk  input  1  rising-edge clock; the only clock.
- nrst  input  1  reset, synchronous, active-low.
- sop  input  1  start of packet; the `coded` value in the same cycle is the packet's first nibble.
- eop  input  1  end of packet; the `coded` value in the same cycle is the packet's last nibble.
- coded  input  4  ADPCM code: bit 3 is the sign, bits 2:0 are the magnitude.
- decoded  output  WIDTH  decoded PCM sample, two's complement, registered.

## Operation
- State registers:
  - `pred`: signed 16-bit sample predictor.
  - `idx`: DWIDTH-bit step index, range 0..88.
  - `active`: 1-bit packet-in-progress flag.
- A nibble is valid in a cycle when `sop` is 1 or `active` is 1.
- `active` updates as follows:
  - Set on `sop`.
  - Cleared on `eop`; `eop` takes precedence over `sop` for the next value of `active`.
- On `sop`, decode the cycle's nibble with the effective `pred` = 0 and `idx` = 0, ignoring the stored values.
- Step lookup: `step` = STEP[idx], from the standard 89-entry IMA table (7, 8, 9, 10, 11, 12, 13, 14, 16, 17, …, 29794, 32767). Implement it as a combinational ROM.
- Difference: `diff` = (step>>3) + (coded[2] ? step : 0) + (coded[1] ? step>>1 : 0) + (coded[0] ? step>>2 : 0). Use unsigned arithmetic at least 17 bits wide.
- New sample: `pred` − `diff` if coded[3] is 1, otherwise `pred` + `diff`. Compute at 18 bits signed, then saturate to [−32768, 32767].
- Index update: `idx` += ADJ[coded[2:0]], where ADJ = {−1, −1, −1, −1, 2, 4, 6, 8}. Clamp the result to [0, 88].
- On a valid nibble, the saturated sample is written to both `pred` and `decoded`, and the clamped index to `idx`.
- On a non-valid cycle, `pred`, `idx` and `decoded` hold their values. `coded` is ignored.
- `sop` during an active packet restarts decoding from `pred` = 0 and `idx` = 0.

## Timing
- Reset: when `nrst` = 0 at a rising edge, the next values are `decoded` = 0, `pred` = 0, `idx` = 0, `active` = 0. This applies in every state, including mid-packet. `sop`, `eop` and `coded` are ignored in that cycle.
- Latency: 1 cycle. The code sampled at edge N appears on `decoded` after edge N.
- Throughput: one nibble per cycle with no stalls. No backpressure.
- `sop` and `eop` together form a one-nibble packet. It is decoded from the reset predictor state, and `active` stays 0.
- `eop` without a preceding `sop` or active packet: no effect.
- After `eop`, `decoded` holds the last sample until the next `sop`.

## Test plan
- Reset: hold `nrst` = 0 for 2 cycles with random `sop`/`coded`, then release → `decoded` = 0 and no decode occurs until `sop`.
- Positive decode: `sop` with `coded` = 0x7, then `coded` = 0x7 → `decoded` = 11 (`idx` becomes 8), then 41 (`idx` becomes 16).
- Negative decode and index floor:
  - `sop` with `coded` = 0xF → `decoded` = −11 (0xFFF5).
  - `sop` with `coded` = 0x0 → `decoded` = 0 and `idx` stays 0.
- Saturation: `sop`, then 40 cycles of `coded` = 0x7 → `decoded` reaches 32767 and stays there, and `idx` holds at 88. Repeat with 0xF → −32768.
- Framing:
  - 4-nibble packet (`sop`, 2 middle nibbles, `eop`), then idle cycles with changing `coded` → `decoded` holds its last value.
  - A new `sop` restarts from 0, so first nibble 0x7 gives 11 again.
  - `sop` and `eop` in the same cycle with 0x7 → 11, then hold.
- Reset mid-packet: assert `nrst` = 0 for one cycle during a packet → `decoded` = 0. Following nibbles are ignored until the next `sop`.
